pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generation unit for the fetch stage of the pipelined core. It replaces the plain PC register and adds the following:
- a configurable reset vector and PC width
- a start/idle state machine
- prioritised exception and branch redirects
- a one-entry pending-redirect buffer, so a redirect raised during a stall is never lost
- target alignment checking
It feeds the instruction memory address and the IF/ID pipeline register.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_PC, 0, PC value after reset and while idle.
INSTR_BYTES, 4, sequential increment; power of two >= 1; ALIGN_BITS = log2(INSTR_BYTES).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
start_i  input  1  run enable; low requests return to idle.
stall_i  input  1  hazard-unit stall.
mem_stall_i  input  1  memory/cache stall.
pc_write_i  input  1  PC write enable from the hazard unit.
exc_valid_i  input  1  exception redirect request (single-cycle pulse).
exc_pc_i  input  XLEN  exception vector target.
br_valid_i  input  1  branch/jump redirect request (single-cycle pulse).
br_pc_i  input  XLEN  branch/jump target.
pc_o  output  XLEN  current fetch PC.
pc_valid_o  output  1  pc_o is a valid fetch address.
redirect_o  output  1  one-cycle pulse: the last update loaded a redirect target.
pending_o  output  1  a redirect is buffered and waiting for advance.
misalign_o  output  1  one-cycle pulse: the last loaded target had nonzero low ALIGN_BITS.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or with a redirect pending): pc_o=RESET_PC, pc_valid_o=0, redirect_o=0, misalign_o=0, pending cleared (pending_o=0), state IDLE.
- adv = ~stall_i & ~mem_stall_i & pc_write_i, evaluated each rising edge.
- State IDLE:
  - pc_o holds RESET_PC and pc_valid_o=0.
  - Redirect inputs are ignored; nothing is buffered.
  - Edge with start_i=1 -> RUN with pc_valid_o=1; pc_o remains RESET_PC, which is the first fetch. Stalls do not block this transition.
- State RUN, edge with adv=1, next PC in priority order:
  1. exc_valid_i -> exc_pc_i
  2. br_valid_i -> br_pc_i
  3. pending buffer -> buffered target
  4. otherwise pc_o + INSTR_BYTES, modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32, INSTR_BYTES=4).
- Cases 1-3 on that edge:
  - Set redirect_o=1 for one cycle.
  - Clear the pending buffer.
  - Load the target with its low ALIGN_BITS forced to 0.
  - Pulse misalign_o if any of those bits were 1.
  - Sequential updates never assert redirect_o or misalign_o.
- State RUN, edge with adv=0:
  - pc_o holds its value.
  - exc_valid_i or br_valid_i is written into the pending buffer: valid, is_exc flag, raw target.
  - Overwrite rule: an exception overwrites any entry. A branch overwrites an empty entry or a branch entry, newest wins. A branch never overwrites a buffered exception.
  - Exception and branch in the same cycle: the exception is stored.
  - pending_o reflects buffer valid and goes high the cycle after capture.
- State RUN, edge with start_i=0:
  - With adv=1: pc_o<=RESET_PC, pc_valid_o<=0, pending cleared, state IDLE. This takes precedence over redirects on that edge.
  - With adv=0: no action; the request is honoured at the first edge where adv=1, provided start_i is still low.
- redirect_o and misalign_o are registered. Each is high for exactly the cycle following the loading edge.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and start:
  - Assert rst_i with RESET_PC=0x100, release it, hold start_i=0 for 3 cycles -> pc_o=0x100, pc_valid_o=0.
  - Raise start_i -> pc_valid_o=1, then pc_o sequence 0x100, 0x104, 0x108.
- Stall hold and wrap:
  - Run from 0xFFFFFFF8 with mem_stall_i=1 for 2 cycles -> pc_o holds 0xFFFFFFF8.
  - Release the stall -> 0xFFFFFFFC, then 0x00000000, with no redirect_o.
- Priority on advance:
  - With adv=1, pc_o=0x200, pulse exc_valid_i (0x80) and br_valid_i (0x400) together -> pc_o=0x80, redirect_o pulses once, next 0x84.
- Pending buffer:
  - With pc_o=0x300 and stall_i=1, pulse br_valid_i (0x500), then exc_valid_i (0x40), then br_valid_i (0x600) -> pending_o=1 and pc_o holds 0x300.
  - Release the stall -> pc_o=0x40, pending_o=0, redirect_o pulses.
- Misaligned target:
  - With adv=1, br_valid_i, br_pc_i=0x1003 -> pc_o=0x1000, misalign_o and redirect_o pulse for one cycle.
- Stop and async reset:
  - Drop start_i while stall_i=1 -> pc_o holds; release the stall -> pc_o=RESET_PC, pc_valid_o=0.
  - Assert rst_i mid-cycle with a redirect pending -> outputs go to reset values immediately, pending_o=0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the hazard/branch logic and the PC generator.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic            stall_i;
    logic            mem_stall_i;
    logic            pc_write_i;
    logic            exc_valid_i;
    logic [XLEN-1:0] exc_pc_i;
    logic            br_valid_i;
    logic [XLEN-1:0] br_pc_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            redirect_o;
    logic            pending_o;
    logic            misalign_o;

    // Pipeline-control side: drives requests, observes the fetch PC.
    modport master (
        output start_i, stall_i, mem_stall_i, pc_write_i,
        output exc_valid_i, exc_pc_i, br_valid_i, br_pc_i,
        input  pc_o, pc_valid_o, redirect_o, pending_o, misalign_o
    );

    // PC generator side.
    modport slave (
        input  start_i, stall_i, mem_stall_i, pc_write_i,
        input  exc_valid_i, exc_pc_i, br_valid_i, br_pc_i,
        output pc_o, pc_valid_o, redirect_o, pending_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter with start/idle control, prioritised redirects
// and a one-entry buffer that holds a redirect raised while the PC is frozen.
module pc_gen #(
    parameter int unsigned          XLEN        = 32,
    parameter logic [XLEN-1:0]      RESET_PC    = '0,
    parameter int unsigned          INSTR_BYTES = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_gen_if.slave  bus
);
    // Mask form handles INSTR_BYTES == 1 (no alignment bits) without a zero-width slice.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic            valid;
        logic            is_exc;
        logic [XLEN-1:0] target;
    } pend_t;

    state_e          state_q, state_d;
    pend_t           pend_q, pend_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;

    logic            adv;
    logic            redir_take;
    logic [XLEN-1:0] redir_tgt;

    assign adv = ~bus.stall_i & ~bus.mem_stall_i & bus.pc_write_i;

    // Redirect source in priority order: exception, branch, buffered entry.
    assign redir_take = bus.exc_valid_i | bus.br_valid_i | pend_q.valid;
    assign redir_tgt  = bus.exc_valid_i ? bus.exc_pc_i :
                        bus.br_valid_i  ? bus.br_pc_i  : pend_q.target;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start leaves idle at once; stop waits for an advancing edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start_i)           state_d = ST_RUN;
            ST_RUN:  if (adv && !bus.start_i)   state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Next values for the PC, status pulses and the pending buffer.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        pend_d     = pend_q;
        case (state_q)
            ST_IDLE: begin
                pc_d       = RESET_PC;
                pc_valid_d = bus.start_i;
                pend_d     = '0;
            end
            ST_RUN: begin
                pc_valid_d = 1'b1;
                if (adv) begin
                    if (!bus.start_i) begin
                        pc_d       = RESET_PC;
                        pc_valid_d = 1'b0;
                        pend_d     = '0;
                    end else if (redir_take) begin
                        pc_d       = redir_tgt & ~ALIGN_MASK;
                        redirect_d = 1'b1;
                        misalign_d = |(redir_tgt & ALIGN_MASK);
                        pend_d     = '0;
                    end else begin
                        pc_d = pc_q + PC_INC;
                    end
                end else if (bus.exc_valid_i) begin
                    pend_d.valid  = 1'b1;
                    pend_d.is_exc = 1'b1;
                    pend_d.target = bus.exc_pc_i;
                end else if (bus.br_valid_i && !(pend_q.valid && pend_q.is_exc)) begin
                    pend_d.valid  = 1'b1;
                    pend_d.is_exc = 1'b0;
                    pend_d.target = bus.br_pc_i;
                end
            end
            default: begin
                pc_d       = RESET_PC;
                pc_valid_d = 1'b0;
                pend_d     = '0;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = pc_valid_q;
    assign bus.redirect_o = redirect_q;
    assign bus.pending_o  = pend_q.valid;
    assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, async-reset sequence,
// then randomized traffic against a rule-level reference model.
module tb_pc_gen;
    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam int unsigned IB     = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    pc_gen_if #(.XLEN(XLEN)) bus();

    pc_gen #(
        .XLEN(XLEN),
        .RESET_PC(RST_PC),
        .INSTR_BYTES(IB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_exc;
        logic [31:0] tgt;
    } entry_t;

    bit          m_run;
    logic [31:0] m_pc;
    bit          m_red;
    bit          m_mis;
    entry_t      m_pend[$];

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RST_PC;
        m_red = 1'b0;
        m_mis = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_edge();
        bit          adv;
        bit          take;
        logic [31:0] tgt;
        entry_t      e;
        m_red = 1'b0;
        m_mis = 1'b0;
        adv   = !bus.stall_i && !bus.mem_stall_i && bus.pc_write_i;
        if (!m_run) begin
            if (bus.start_i) m_run = 1'b1;
        end else if (adv && !bus.start_i) begin
            m_run = 1'b0;
            m_pc  = RST_PC;
            m_pend.delete();
        end else if (adv) begin
            take = 1'b1;
            tgt  = 32'h0;
            if (bus.exc_valid_i)      tgt = bus.exc_pc_i;
            else if (bus.br_valid_i)  tgt = bus.br_pc_i;
            else if (m_pend.size() != 0) tgt = m_pend[0].tgt;
            else take = 1'b0;
            if (take) begin
                m_pc  = 32'((tgt / IB) * IB);
                m_mis = (tgt % IB) != 0;
                m_red = 1'b1;
                m_pend.delete();
            end else begin
                m_pc = m_pc + 32'(IB);
            end
        end else if (bus.exc_valid_i) begin
            e.is_exc = 1'b1;
            e.tgt    = bus.exc_pc_i;
            m_pend.delete();
            m_pend.push_back(e);
        end else if (bus.br_valid_i) begin
            if (m_pend.size() == 0 || !m_pend[0].is_exc) begin
                e.is_exc = 1'b0;
                e.tgt    = bus.br_pc_i;
                m_pend.delete();
                m_pend.push_back(e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},       bus.pc_o,       m_pc);
        chk({tag, ".valid"},    32'(bus.pc_valid_o), 32'(m_run));
        chk({tag, ".redirect"}, 32'(bus.redirect_o), 32'(m_red));
        chk({tag, ".pending"},  32'(bus.pending_o),  32'(m_pend.size() != 0));
        chk({tag, ".misalign"}, 32'(bus.misalign_o), 32'(m_mis));
    endtask

    // One rising edge; the model sees the same inputs the DUT sampled.
    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic s, input logic st, input logic ms, input logic pw,
                          input logic e, input logic [31:0] ep,
                          input logic b, input logic [31:0] bp);
        bus.start_i     = s;
        bus.stall_i     = st;
        bus.mem_stall_i = ms;
        bus.pc_write_i  = pw;
        bus.exc_valid_i = e;
        bus.exc_pc_i    = ep;
        bus.br_valid_i  = b;
        bus.br_pc_i     = bp;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s, st, ms, pw, e;
        logic [31:0] ep;
        logic        b;
        logic [31:0] bp;
        logic [31:0] pc;
        logic        v, r, p, m;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic s, input logic st, input logic ms, input logic pw,
                       input logic e, input logic [31:0] ep,
                       input logic b, input logic [31:0] bp,
                       input logic [31:0] pc, input logic v, input logic r,
                       input logic p, input logic m);
        vec_t x;
        x.s = s; x.st = st; x.ms = ms; x.pw = pw; x.e = e; x.ep = ep;
        x.b = b; x.bp = bp; x.pc = pc; x.v = v; x.r = r; x.p = p; x.m = m;
        vt.push_back(x);
    endtask

    initial begin
        //  s  st ms pw  e  ep            b  bp             pc            v  r  p  m
        add(0, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h100,      0, 0, 0, 0);
        add(0, 0, 0, 1,  0, 32'h0,        1, 32'h500,       32'h100,      0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h44,       0, 32'h0,         32'h100,      0, 0, 0, 0);
        add(1, 1, 0, 1,  0, 32'h0,        0, 32'h0,         32'h100,      1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h104,      1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h108,      1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        1, 32'h200,       32'h200,      1, 1, 0, 0);
        add(1, 0, 0, 1,  1, 32'h80,       1, 32'h400,       32'h80,       1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h84,       1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        1, 32'hFFFFFFF8,  32'hFFFFFFF8, 1, 1, 0, 0);
        add(1, 0, 1, 1,  0, 32'h0,        0, 32'h0,         32'hFFFFFFF8, 1, 0, 0, 0);
        add(1, 0, 1, 1,  0, 32'h0,        0, 32'h0,         32'hFFFFFFF8, 1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'hFFFFFFFC, 1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h0,        1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        1, 32'h300,       32'h300,      1, 1, 0, 0);
        add(1, 1, 0, 1,  0, 32'h0,        1, 32'h500,       32'h300,      1, 0, 1, 0);
        add(1, 1, 0, 1,  1, 32'h40,       0, 32'h0,         32'h300,      1, 0, 1, 0);
        add(1, 1, 0, 1,  0, 32'h0,        1, 32'h600,       32'h300,      1, 0, 1, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h40,       1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h44,       1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        1, 32'h1003,      32'h1000,     1, 1, 0, 1);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h1004,     1, 0, 0, 0);
        add(1, 1, 0, 1,  0, 32'h0,        1, 32'h700,       32'h1004,     1, 0, 1, 0);
        add(1, 0, 0, 0,  0, 32'h0,        1, 32'h800,       32'h1004,     1, 0, 1, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h800,      1, 1, 0, 0);
        add(1, 1, 0, 1,  1, 32'hA00,      1, 32'hB00,       32'h800,      1, 0, 1, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'hA00,      1, 1, 0, 0);
        add(0, 1, 0, 1,  0, 32'h0,        0, 32'h0,         32'hA00,      1, 0, 0, 0);
        add(0, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h100,      0, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h100,      1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 32'h0,        0, 32'h0,         32'h104,      1, 0, 0, 0);

        // Reset with quiet inputs, release away from the clock edge.
        set_in(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst.pc",       bus.pc_o,             RST_PC);
        chk("rst.valid",    32'(bus.pc_valid_o),  32'h0);
        chk("rst.redirect", 32'(bus.redirect_o),  32'h0);
        chk("rst.pending",  32'(bus.pending_o),   32'h0);
        chk("rst.misalign", 32'(bus.misalign_o),  32'h0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].s, vt[i].st, vt[i].ms, vt[i].pw, vt[i].e, vt[i].ep, vt[i].b, vt[i].bp);
            step();
            chk($sformatf("vec%0d.pc", i),       bus.pc_o,            vt[i].pc);
            chk($sformatf("vec%0d.valid", i),    32'(bus.pc_valid_o), 32'(vt[i].v));
            chk($sformatf("vec%0d.redirect", i), 32'(bus.redirect_o), 32'(vt[i].r));
            chk($sformatf("vec%0d.pending", i),  32'(bus.pending_o),  32'(vt[i].p));
            chk($sformatf("vec%0d.misalign", i), 32'(bus.misalign_o), 32'(vt[i].m));
        end

        // Async reset mid-cycle while a redirect is buffered under a stall.
        set_in(1, 1, 0, 1, 0, 32'h0, 1, 32'h900);
        step();
        chk("arst.pre_pending", 32'(bus.pending_o), 32'h1);
        set_in(1, 1, 0, 1, 0, 32'h0, 0, 32'h0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("arst.pc",       bus.pc_o,             RST_PC);
        chk("arst.valid",    32'(bus.pc_valid_o),  32'h0);
        chk("arst.pending",  32'(bus.pending_o),   32'h0);
        chk("arst.redirect", 32'(bus.redirect_o),  32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_in(1, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        step();
        chk("arst.restart_pc",    bus.pc_o,            RST_PC);
        chk("arst.restart_valid", 32'(bus.pc_valid_o), 32'h1);
        step();
        chk("arst.no_stale_pc",   bus.pc_o,            RST_PC + 32'(IB));

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic        s, e, b;
            logic [31:0] ep, bp;
            s  = ($urandom_range(0, 15) != 0);
            e  = s && ($urandom_range(0, 7) == 0);
            b  = s && ($urandom_range(0, 3) == 0);
            ep = $urandom();
            bp = $urandom();
            if ($urandom_range(0, 1) == 1) ep = ep & 32'hFFFFFFFC;
            if ($urandom_range(0, 1) == 1) bp = bp & 32'hFFFFFFFC;
            set_in(s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) != 0), e, ep, b, bp);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
